// File: rtl/shiftnbit_burst.sv
// Bidirectional n-bit shift register with parallel load, single-step shift and a counted burst engine.
// Optional rotate mode is compiled in with `define SHIFTNBIT_ROT_EN (adds the Rot port).
module shiftnbit_burst #(
    parameter int n  = 8,
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          L,
    input  logic [n-1:0]  R,
    input  logic          Dir,
    input  logic          InHi,
    input  logic          InLo,
    input  logic          En,
    input  logic          Start,
    input  logic [CW-1:0] Cnt,
`ifdef SHIFTNBIT_ROT_EN
    input  logic          Rot,
`endif
    output logic [n-1:0]  Q,
    output logic          SOut,
    output logic          Busy,
    output logic          Done
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic          dir_l;
    logic [CW-1:0] rem;
    logic          sh_dir;
    logic          sh_rot;
    logic [n-1:0]  sh_q;
    logic          sh_out;
`ifdef SHIFTNBIT_ROT_EN
    logic          rot_l;
`endif

    // A burst shifts with the direction/mode captured at Start; idle single shifts use live inputs.
    always_comb begin
        sh_dir = (state == BURST) ? dir_l : Dir;
`ifdef SHIFTNBIT_ROT_EN
        sh_rot = (state == BURST) ? rot_l : Rot;
`else
        sh_rot = 1'b0;
`endif
        sh_q   = Q;
        sh_out = SOut;
        if (!sh_dir) begin
            sh_out = Q[0];
            sh_q   = {(sh_rot ? Q[0] : InHi), Q[n-1:1]};
        end else begin
            sh_out = Q[n-1];
            sh_q   = {Q[n-2:0], (sh_rot ? Q[n-1] : InLo)};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Q     <= '0;
            SOut  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            dir_l <= 1'b0;
            rem   <= '0;
`ifdef SHIFTNBIT_ROT_EN
            rot_l <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (L) begin
                        Q <= R;
                    end else if (Start) begin
                        dir_l <= Dir;
                        rem   <= Cnt;
`ifdef SHIFTNBIT_ROT_EN
                        rot_l <= Rot;
`endif
                        if (Cnt != '0) begin
                            state <= BURST;
                            Busy  <= 1'b1;
                        end else begin
                            Done <= 1'b1;
                        end
                    end else if (En) begin
                        Q    <= sh_q;
                        SOut <= sh_out;
                    end
                end
                BURST: begin
                    if (L) begin
                        // Abort: load wins, no completion pulse.
                        Q     <= R;
                        state <= IDLE;
                        Busy  <= 1'b0;
                        rem   <= '0;
                    end else begin
                        Q    <= sh_q;
                        SOut <= sh_out;
                        rem  <= rem - 1'b1;
                        if (rem == 1) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftnbit_burst.sv
// Scoreboard bench for shiftnbit_burst: randomized bursts, loads and single shifts against a
// behavioural model; a negedge monitor checks per-shift SOut and each Done against queued expectations.
module tb_shiftnbit_burst;

    localparam int NB   = 8;
    localparam int CWB  = 4;
    localparam int MASK = (1 << NB) - 1;

    typedef struct {
        int q;
        int len;
    } done_exp_t;

    logic            Clk;
    logic            Rst;
    logic            L;
    logic [NB-1:0]   R;
    logic            Dir;
    logic            InHi;
    logic            InLo;
    logic            En;
    logic            Start;
    logic [CWB-1:0]  Cnt;
`ifdef SHIFTNBIT_ROT_EN
    logic            Rot;
`endif
    logic [NB-1:0]   Q;
    logic            SOut;
    logic            Busy;
    logic            Done;

    shiftnbit_burst #(.n(NB), .CW(CWB)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .L     (L),
        .R     (R),
        .Dir   (Dir),
        .InHi  (InHi),
        .InLo  (InLo),
        .En    (En),
        .Start (Start),
        .Cnt   (Cnt),
`ifdef SHIFTNBIT_ROT_EN
        .Rot   (Rot),
`endif
        .Q     (Q),
        .SOut  (SOut),
        .Busy  (Busy),
        .Done  (Done)
    );

    int        total = 0;
    int        bad   = 0;
    int        m_q   = 0;
    int        m_sout = 0;
    int        sout_q[$];
    done_exp_t done_q[$];
    int        busy_run = 0;
    bit        prev_busy = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: one shift of an NB-bit word, arithmetic on an int.
    function automatic void mshift(input bit dir, input bit fill_in, input bit rot);
        int out_bit;
        int fill;
        if (!dir) begin
            out_bit = m_q & 1;
            fill    = rot ? out_bit : int'(fill_in);
            m_q     = (m_q >> 1) | (fill << (NB - 1));
        end else begin
            out_bit = (m_q >> (NB - 1)) & 1;
            fill    = rot ? out_bit : int'(fill_in);
            m_q     = ((m_q << 1) | fill) & MASK;
        end
        m_sout = out_bit;
    endfunction

    // Monitor: a shift is expected at every edge that follows a busy cycle; Done carries the final state.
    always @(negedge Clk) begin
        if (prev_busy) begin
            check("sout_avail", 32'(sout_q.size() != 0), 1);
            if (sout_q.size() != 0) check("sout", 32'(SOut), sout_q.pop_front());
        end
        if (Done === 1'b1) begin
            check("done_avail", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                done_exp_t e;
                e = done_q.pop_front();
                check("done_q", 32'(Q), e.q);
                check("busy_len", busy_run, e.len);
            end
            busy_run = 0;
        end else if (Busy === 1'b1) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
        prev_busy = (Busy === 1'b1);
    end

    task automatic load(input int v);
        L = 1'b1;
        R = NB'(v);
        tick();
        L = 1'b0;
        m_q = v & MASK;
        check("load_q", 32'(Q), m_q);
    endtask

    task automatic en_shift();
        bit d, hi, lo, rt;
        d  = 1'($urandom);
        hi = 1'($urandom);
        lo = 1'($urandom);
        rt = 1'b0;
`ifdef SHIFTNBIT_ROT_EN
        rt  = 1'($urandom);
        Rot = rt;
`endif
        Dir = d; InHi = hi; InLo = lo; En = 1'b1;
        tick();
        En = 1'b0;
        mshift(d, d ? lo : hi, rt);
        check("en_q", 32'(Q), m_q);
        check("en_sout", 32'(SOut), m_sout);
    endtask

    // bits < 0 selects a random serial stream; abort_at = burst cycle (1-based) hit by L or Rst.
    task automatic burst(input bit dir, input int cnt, input int bits, input bit rot,
                         input int abort_at, input bit abort_rst);
        bit stream[16];
        int last;
        for (int k = 0; k < 16; k++)
            stream[k] = (bits < 0) ? 1'($urandom) : 1'((bits >> k) & 1);
        last = (abort_at != 0) ? abort_at - 1 : cnt;
        for (int k = 0; k < last; k++) begin
            mshift(dir, stream[k], rot);
            sout_q.push_back(m_sout);
        end
        if (abort_at != 0) begin
            if (abort_rst) begin
                m_q = 0;
                m_sout = 0;
            end else begin
                m_q = 'h3C;
            end
            sout_q.push_back(m_sout);
        end else begin
            done_q.push_back('{q: m_q, len: cnt});
        end

        Dir = dir; Cnt = CWB'(cnt); Start = 1'b1;
`ifdef SHIFTNBIT_ROT_EN
        Rot = rot;
`endif
        tick();
        Start = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            En    = 1'($urandom);
            Start = 1'($urandom);
            Cnt   = CWB'($urandom);
`ifdef SHIFTNBIT_ROT_EN
            Rot   = 1'($urandom);
`endif
            if (dir == 1'b0) begin
                InHi = stream[k];
                InLo = 1'($urandom);
            end else begin
                InLo = stream[k];
                InHi = 1'($urandom);
            end
            Dir = 1'($urandom);
            if (abort_at != 0 && k == abort_at - 1) begin
                if (abort_rst) Rst = 1'b1;
                else begin
                    L = 1'b1;
                    R = 8'h3C;
                end
                tick();
                Rst = 1'b0; L = 1'b0; Start = 1'b0; En = 1'b0;
                check("abort_q", 32'(Q), m_q);
                check("abort_sout", 32'(SOut), m_sout);
                check("abort_busy", 32'(Busy), 0);
                check("abort_done", 32'(Done), 0);
                tick();
                check("abort_nodone", 32'(Done), 0);
                break;
            end
            tick();
        end
        En = 1'b0;
        Start = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; L = 1'b0; R = '0; Dir = 1'b0; InHi = 1'b0; InLo = 1'b0;
        En = 1'b0; Start = 1'b0; Cnt = '0;
`ifdef SHIFTNBIT_ROT_EN
        Rot = 1'b0;
`endif
        tick();
        tick();
        Rst = 1'b0;
        check("rst_q", 32'(Q), 0);
        check("rst_sout", 32'(SOut), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);

        load('hA5);
        burst(1'b0, 8, 0, 1'b0, 0, 1'b0);
        check("ser_q", 32'(Q), 0);

        load(0);
        burst(1'b1, 4, 'hB, 1'b0, 0, 1'b0);
        check("deser_q", 32'(Q), 'h0D);

        load(int'($urandom & MASK));
        burst(1'($urandom), 0, -1, 1'b0, 0, 1'b0);
        check("cnt0_q", 32'(Q), m_q);
        check("cnt0_busy", 32'(Busy), 0);

        burst(1'($urandom), 15, -1, 1'b0, 0, 1'b0);

        load('hA5);
        burst(1'b0, 8, -1, 1'b0, 3, 1'b0);
        burst(1'b1, 10, -1, 1'b0, 5, 1'b1);

        // Back-to-back: the second Start lands in the Done cycle of the first.
        burst(1'b0, 3, -1, 1'b0, 0, 1'b0);
        burst(1'b1, 5, -1, 1'b0, 0, 1'b0);
        tick();

        for (int i = 0; i < 30; i++) begin
            case ($urandom % 3)
                0: load(int'($urandom & MASK));
                1: en_shift();
                default: burst(1'($urandom), int'($urandom % 16), -1, 1'b0, 0, 1'b0);
            endcase
        end

`ifdef SHIFTNBIT_ROT_EN
        load('h81);
        burst(1'b0, 1, -1, 1'b1, 0, 1'b0);
        check("rot1_q", 32'(Q), 'hC0);
        check("rot1_sout", 32'(SOut), 1);
        load('h81);
        burst(1'($urandom), 8, -1, 1'b1, 0, 1'b0);
        check("rot8_q", 32'(Q), 'h81);
`endif

        tick();
        tick();
        tick();
        check("sout_drained", 32'(sout_q.size()), 0);
        check("done_drained", 32'(done_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shiftnbit_burst.md
# shiftnbit_burst

Parametrised bidirectional shift register with parallel load, single-step shifting and a counted burst engine. It extends the plain n-bit load/shift register: a programmable width, both shift directions, a serial output, and a Start/Busy/Done handshake that runs a burst of 0..2^CW-1 shifts with no per-cycle control. It sits between parallel datapaths and bit-serial links as a serialiser or deserialiser.

## Interface
- n, 8, register width (≥2)
- CW, 4, width of the burst count

- Clk  in  1  clock, all state changes on posedge
- Rst  in  1  synchronous reset, active-high
- L  in  1  parallel load strobe
- R  in  n  parallel load data
- Dir  in  1  0 = shift toward bit 0 (InHi enters Q[n-1]); 1 = shift toward bit n-1 (InLo enters Q[0])
- InHi  in  1  serial input used when Dir=0
- InLo  in  1  serial input used when Dir=1
- En  in  1  single shift this cycle (idle only)
- Start  in  1  begin a burst (idle only)
- Cnt  in  CW  number of shifts in the burst, sampled with Start
- Rot  in  1  rotate instead of serial fill (present only with SHIFTNBIT_ROT_EN)
- Q  out  n  register contents
- SOut  out  1  bit that left the register on the most recent shift
- Busy  out  1  burst in progress
- Done  out  1  one-cycle pulse at burst completion

## Operation
- The shift register has two states: IDLE and BURST. It also holds a latched direction dirL, a remaining-shift counter rem (CW bits), and rotL when the macro is defined.
- Reset: Q=0, SOut=0, Busy=0, Done=0, state IDLE, rem=0. Rst overrides every other input.
- Shift with Dir=0: Q[k]<=Q[k+1] for k<n-1, Q[n-1]<=InHi, SOut<=Q[0].
- Shift with Dir=1: Q[k]<=Q[k-1] for k>0, Q[0]<=InLo, SOut<=Q[n-1].
- Priority in IDLE, highest first: L (Q<=R, SOut unchanged), then Start, then En (one shift using the live Dir). If none is asserted, Q holds.
- Start in IDLE latches dirL<=Dir and rem<=Cnt.
  - Cnt≠0: go to BURST and set Busy=1.
  - Cnt=0: no shift, stay IDLE, Done=1 for one cycle.
- BURST: every cycle performs one shift using dirL and decrements rem. The live InHi/InLo are sampled each cycle. On the shift where rem==1, go to IDLE with Busy=0 and Done=1.
- In BURST, L aborts the burst: Q<=R, go to IDLE, Busy=0, no Done, rem=0.
- In BURST, Start and En are ignored, and Dir changes have no effect.
- Done is high for exactly one cycle and is cleared on the following edge regardless of inputs.

## Timing
- Start sampled at edge t with Cnt=N>0:
  - shifts occur at edges t+1 … t+N;
  - Busy is high from after edge t until edge t+N;
  - Done is high for the cycle after edge t+N;
  - Q holds its final value from edge t+N.
- Total latency from Start to Done is N+1 cycles. Busy is high for N cycles.
- Start with Cnt=0 at edge t: Done is high after edge t and Busy stays 0.
- A new Start is accepted in the same cycle Done is high, so bursts can run back-to-back with one idle cycle between them.
- En single shift: Q updates at the sampling edge, latency 1.
- Rst asserted mid-burst: after that edge all outputs hold their reset values and Done does not pulse.

## Configuration
- SHIFTNBIT_ROT_EN defined:
  - the Rot port exists and is latched as rotL with Start;
  - an En shift uses the live Rot;
  - when rotation is active, the vacating end takes the outgoing bit (Q[0] for Dir=0, Q[n-1] for Dir=1), and InHi/InLo are ignored;
  - SOut still reports the outgoing bit.
- SHIFTNBIT_ROT_EN undefined: the Rot port and rotation logic are absent, and every shift is a serial fill.

## Test plan
- Reset, then load: Rst=1 for 2 cycles → Q=0x00, Busy=0, Done=0; then L=1 with R=0xA5 → Q=0xA5 after 1 edge.
- Serialise, Dir=0: Q=0xA5, InHi=0, Start with Cnt=8 → SOut sequence 1,0,1,0,0,1,0,1; Busy high for 8 cycles; Done for 1 cycle; final Q=0x00.
- Deserialise, Dir=1: Q=0, InLo stream 1,1,0,1, Start with Cnt=4 → Q=0x0D at Done.
- Boundaries:
  - Start with Cnt=0 → Done the next cycle, Busy never high, Q unchanged.
  - Start with Cnt=15 → exactly 15 shifts.
- Abort and interference:
  - L with R=0x3C at the 3rd burst cycle → Q=0x3C, Busy=0, no Done.
  - Rst mid-burst → all outputs 0.
  - En and Start during a burst → no extra shifts.
- With SHIFTNBIT_ROT_EN: Q=0x81, Rot=1, Dir=0, Start with Cnt=1 → Q=0xC0, SOut=1; Cnt=8 returns Q to the start value.
